// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: word/field widths and FSM encoding shared by the fetch slice
package fetch_unit_pkg;
    localparam int WORD_W = 16;
    localparam int OPCODE_W = 4;
    localparam int FUNCT_W = 6;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, HALTED = 2'd3} state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read channel between the fetch unit and memory
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic i_readM;
    word_t i_address;
    word_t i_data;
    logic i_ready;
    modport master (output i_readM, i_address, input i_data, i_ready);
    modport slave (input i_readM, i_address, output i_data, i_ready);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry store for a word that returns while the IF/ID register is stalled
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  logic  clear,
    input  word_t d_data,
    input  word_t d_pc,
    output word_t q_data,
    output word_t q_pc,
    output logic  q_valid
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_data <= '0;
            q_pc <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_data <= d_data;
            q_pc <= d_pc;
            q_valid <= 1'b1;
        end else if (clear) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with IF/ID register, skid entry, redirect and halt
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    fetch_unit_if.master        mem,
    input  logic                stall,
    input  logic                redirect,
    input  word_t               redirect_pc,
    input  logic                halt,
    output logic                inst_valid,
    output word_t               instruction,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  funct,
    output word_t               inst_pc,
    output word_t               next_pc
);
    state_t state, state_nx;
    word_t pc, skid_data, skid_pc;
    logic skid_valid, flush, stop, take, to_skid, to_out, pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // HALTED is sticky; a redirect outranks halt because the HLT is on the wrong path
    always_comb begin
        state_nx = state == HALTED ? HALTED :
                   redirect        ? REQ :
                   halt            ? HALTED :
                   state == IDLE   ? REQ :
                   state == HOLD   ? (stall ? HOLD : REQ) :
                   to_skid         ? HOLD : REQ;
    end

    always_comb begin
        mem.i_readM = state == REQ;
        flush = state != HALTED && redirect;
        stop = state != HALTED && halt && !redirect;
        take = state == REQ && mem.i_ready && !redirect && !halt;
        to_skid = take && stall && inst_valid;
        to_out = take && !to_skid;
        pop = state == HOLD && skid_valid && !stall && !redirect && !halt;
    end

    assign mem.i_address = pc;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (to_skid),
        .clear   (flush || stop || pop),
        .d_data  (mem.i_data),
        .d_pc    (pc),
        .q_data  (skid_data),
        .q_pc    (skid_pc),
        .q_valid (skid_valid)
    );

    // Without stall an unrefilled IF/ID slot becomes a bubble so no word issues twice
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
            inst_valid <= 1'b0;
            instruction <= '0;
            inst_pc <= '0;
        end else begin
            pc <= flush ? redirect_pc : take ? pc + 1'b1 : pc;
            inst_valid <= (flush || stop) ? 1'b0 : (to_out || pop) ? 1'b1 : stall ? inst_valid : 1'b0;
            instruction <= to_out ? mem.i_data : pop ? skid_data : instruction;
            inst_pc <= to_out ? pc : pop ? skid_pc : inst_pc;
        end
    end

    assign next_pc = inst_pc + 1'b1;
    assign opcode = instruction[WORD_W-1 -: OPCODE_W];
    assign funct = instruction[FUNCT_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors with hand-computed expectations for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    word_t redirect_pc = '0;
    logic inst_valid;
    word_t instruction, inst_pc, next_pc;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0] funct;
    int n_checks = 0;
    int n_pass = 0;

    fetch_unit_if mem();

    fetch_unit u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem         (mem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .opcode      (opcode),
        .funct       (funct),
        .inst_pc     (inst_pc),
        .next_pc     (next_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".readM"}, 32'(mem.i_readM), 32'd0);
        check({tag, ".addr"}, 32'(mem.i_address), 32'd0);
        check({tag, ".valid"}, 32'(inst_valid), 32'd0);
        check({tag, ".instr"}, 32'(instruction), 32'd0);
        check({tag, ".inst_pc"}, 32'(inst_pc), 32'd0);
        check({tag, ".next_pc"}, 32'(next_pc), 32'd1);
        check({tag, ".opcode"}, 32'(opcode), 32'd0);
        check({tag, ".funct"}, 32'(funct), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem.i_data = '0;
        mem.i_ready = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        // first edge after release: IDLE -> REQ
        step();
        check("req0.readM", 32'(mem.i_readM), 32'd1);
        check("req0.addr", 32'(mem.i_address), 32'd0);
        step();
        check("req0.addr_held", 32'(mem.i_address), 32'd0);
        mem.i_ready = 1'b1;
        mem.i_data = 16'h6001;
        step();
        check("f0.valid", 32'(inst_valid), 32'd1);
        check("f0.instr", 32'(instruction), 32'h6001);
        check("f0.opcode", 32'(opcode), 32'h6);
        check("f0.funct", 32'(funct), 32'h01);
        check("f0.inst_pc", 32'(inst_pc), 32'd0);
        check("f0.next_pc", 32'(next_pc), 32'd1);
        check("f0.addr", 32'(mem.i_address), 32'd1);
        for (int a = 1; a < 5; a++) begin
            mem.i_data = 16'h1000 + 16'(a);
            step();
            check("seq.inst_pc", 32'(inst_pc), 32'(a));
        end
        check("seq.instr", 32'(instruction), 32'h1004);
        // stalled output catches the word at pc=5 in the skid entry
        stall = 1'b1;
        mem.i_data = 16'h2345;
        step();
        check("hold.readM", 32'(mem.i_readM), 32'd0);
        check("hold.instr", 32'(instruction), 32'h1004);
        check("hold.inst_pc", 32'(inst_pc), 32'd4);
        check("hold.valid", 32'(inst_valid), 32'd1);
        mem.i_data = 16'hBAD0;
        step();
        check("hold2.instr", 32'(instruction), 32'h1004);
        check("hold2.readM", 32'(mem.i_readM), 32'd0);
        mem.i_ready = 1'b0;
        stall = 1'b0;
        step();
        check("pop.instr", 32'(instruction), 32'h2345);
        check("pop.inst_pc", 32'(inst_pc), 32'd5);
        check("pop.valid", 32'(inst_valid), 32'd1);
        check("pop.readM", 32'(mem.i_readM), 32'd1);
        check("pop.addr", 32'(mem.i_address), 32'd6);
        // redirect with same-cycle data and stall: flush wins
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        stall = 1'b1;
        mem.i_ready = 1'b1;
        mem.i_data = 16'hDEAD;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        mem.i_ready = 1'b0;
        check("redir.valid", 32'(inst_valid), 32'd0);
        check("redir.addr", 32'(mem.i_address), 32'h0040);
        check("redir.readM", 32'(mem.i_readM), 32'd1);
        check("redir.instr", 32'(instruction), 32'h2345);
        halt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        step();
        redirect = 1'b0;
        halt = 1'b0;
        check("hr.readM", 32'(mem.i_readM), 32'd1);
        check("hr.addr", 32'(mem.i_address), 32'h0080);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt.readM", 32'(mem.i_readM), 32'd0);
        check("halt.valid", 32'(inst_valid), 32'd0);
        // HALTED ignores redirect, i_ready and stall
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        mem.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("halted.readM", 32'(mem.i_readM), 32'd0);
            check("halted.addr", 32'(mem.i_address), 32'h0080);
            check("halted.valid", 32'(inst_valid), 32'd0);
        end
        redirect = 1'b0;
        mem.i_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        check_reset_outputs("rst2");
        step();
        reset_n = 1'b1;
        step();
        check("rst2.addr", 32'(mem.i_address), 32'd0);
        check("rst2.readM", 32'(mem.i_readM), 32'd1);
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        check("wrap.addr0", 32'(mem.i_address), 32'hFFFF);
        mem.i_ready = 1'b1;
        mem.i_data = 16'h7ABC;
        step();
        mem.i_ready = 1'b0;
        check("wrap.addr", 32'(mem.i_address), 32'd0);
        check("wrap.inst_pc", 32'(inst_pc), 32'hFFFF);
        check("wrap.next_pc", 32'(next_pc), 32'd0);
        check("wrap.opcode", 32'(opcode), 32'h7);
        check("wrap.funct", 32'(funct), 32'h3C);
        redirect = 1'b1;
        redirect_pc = 16'h0123;
        step();
        redirect = 1'b0;
        check("mid.addr", 32'(mem.i_address), 32'h0123);
        // reset in the middle of an outstanding read
        reset_n = 1'b0;
        #2;
        check_reset_outputs("rst3");
        step();
        reset_n = 1'b1;
        step();
        check("rst3.addr", 32'(mem.i_address), 32'd0);
        check("rst3.readM", 32'(mem.i_readM), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
